// File: rtl/async_pipe_sink.sv
// Clocked sink for the self-timed req/ack pipeline: synchronizes the 4-phase request,
// captures bundled data into a small FIFO and presents it on a valid/ready port.
module async_pipe_sink #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  rx_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [PtrW-1:0]  PtrOne    = {{(PtrW-1){1'b0}}, 1'b1};
  localparam logic [PtrW:0]    CntOne    = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW:0]    FullCount = CntOne << PtrW;
  localparam logic [CNT_W-1:0] RxOne     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StRecover,
    StIdle,
    StAck
  } state_e;

  state_e state_q, state_d;

  logic req_m_q, req_s_q;
  logic [1:0] sync_ok_q;
  logic ack_q, ack_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;

  logic push, pop, full;

  // Two-flop request synchronizer. sync_ok_q marks when req_s_q reflects the live
  // request rather than its reset value, so a request held across reset is not re-captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_m_q   <= 1'b0;
      req_s_q   <= 1'b0;
      sync_ok_q <= 2'b00;
    end else begin
      req_m_q   <= req_in;
      req_s_q   <= req_m_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  assign full = (count_q == FullCount);
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      StRecover: begin
        ack_d = 1'b0;
        if (sync_ok_q[1] && !req_s_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        ack_d = 1'b0;
        // Full is judged on the pre-edge count; a same-cycle pop frees space next cycle.
        if (req_s_q && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        ack_d = 1'b1;
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StRecover;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    rx_count_d = push ? (rx_count_q + RxOne) : rx_count_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRecover;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Storage is deliberately not reset; dout is only meaningful while dout_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ack_out    = ack_q;
  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != '0);
  assign rx_count   = rx_count_q;

endmodule
